// File: rtl/isr_dispatch.sv
// isr_dispatch: takes an interrupt from the controller at an instruction boundary.
// It pushes the CPU context onto a small hardware stack and redirects the PC to
// the vector. RETI pops the context and restores it. A RETI at depth 0 sets a
// sticky error flag.
module isr_dispatch #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_pending,
    input  logic [ADDR_W-1:0] vec_in,
    input  logic              inst_done,
    input  logic              reti,
    input  logic              ei,
    input  logic              di,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [DATA_W-1:0] acc_cur,
    input  logic [3:0]        flags_cur,
    output logic              itr_en,
    output logic              itr_clr,
    output logic              cpu_stall,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ctx_restore,
    output logic [DATA_W-1:0] acc_rest,
    output logic [3:0]        flags_rest,
    output logic [1:0]        nest_depth,
    output logic              reti_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ACK     = 2'd1,
        JUMP    = 2'd2,
        RESTORE = 2'd3
    } state_t;

    state_t            state_q;
    logic              ie_q;
    logic [1:0]        depth_q;
    logic              itr_clr_q;
    logic              cpu_stall_q;
    logic              pc_load_q;
    logic              ctx_restore_q;
    logic [ADDR_W-1:0] pc_next_q;      // also serves as the vector latch in ACK
    logic [DATA_W-1:0] acc_rest_q;
    logic [3:0]        flags_rest_q;
    logic              reti_err_q;

    // Context stack, one field array per saved item
    logic [ADDR_W-1:0] stk_pc_q  [DEPTH];
    logic [DATA_W-1:0] stk_acc_q [DEPTH];
    logic [3:0]        stk_flg_q [DEPTH];
    logic              stk_ie_q  [DEPTH];

    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  pop_idx;
    logic              stack_full;

    assign push_idx   = PTR_W'(depth_q);
    assign pop_idx    = PTR_W'(depth_q - 2'd1);
    assign stack_full = (depth_q >= 2'(DEPTH));

    // Interrupt enable seen by the controller, derived from registered state only
    assign itr_en = ie_q & ~stack_full & (state_q == RUN);

    assign itr_clr     = itr_clr_q;
    assign cpu_stall   = cpu_stall_q;
    assign pc_load     = pc_load_q;
    assign pc_next     = pc_next_q;
    assign ctx_restore = ctx_restore_q;
    assign acc_rest    = acc_rest_q;
    assign flags_rest  = flags_rest_q;
    assign nest_depth  = depth_q;
    assign reti_err    = reti_err_q;

    // Dispatch FSM; strobe outputs are registered on entry to the state they belong to
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= RUN;
            ie_q          <= 1'b0;
            depth_q       <= 2'd0;
            itr_clr_q     <= 1'b0;
            cpu_stall_q   <= 1'b0;
            pc_load_q     <= 1'b0;
            ctx_restore_q <= 1'b0;
            pc_next_q     <= '0;
            acc_rest_q    <= '0;
            flags_rest_q  <= 4'd0;
            reti_err_q    <= 1'b0;
        end else begin
            itr_clr_q     <= 1'b0;
            cpu_stall_q   <= 1'b0;
            pc_load_q     <= 1'b0;
            ctx_restore_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (di) begin
                        ie_q <= 1'b0;
                    end else if (ei) begin
                        ie_q <= 1'b1;
                    end
                    // RETI wins over a simultaneous interrupt; the interrupt is retried next boundary
                    if (inst_done && reti) begin
                        if (depth_q != 2'd0) begin
                            state_q       <= RESTORE;
                            cpu_stall_q   <= 1'b1;
                            pc_load_q     <= 1'b1;
                            ctx_restore_q <= 1'b1;
                            pc_next_q     <= stk_pc_q[pop_idx];
                            acc_rest_q    <= stk_acc_q[pop_idx];
                            flags_rest_q  <= stk_flg_q[pop_idx];
                            ie_q          <= stk_ie_q[pop_idx];
                            depth_q       <= depth_q - 2'd1;
                        end else begin
                            reti_err_q <= 1'b1;
                        end
                    end else if (inst_done && i_pending && itr_en) begin
                        state_q     <= ACK;
                        cpu_stall_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q     <= JUMP;
                    cpu_stall_q <= 1'b1;
                    pc_load_q   <= 1'b1;
                    itr_clr_q   <= 1'b1;
                    pc_next_q   <= vec_in;
                    ie_q        <= 1'b0;
                    depth_q     <= depth_q + 2'd1;
                end
                JUMP: begin
                    state_q <= RUN;
                end
                RESTORE: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Push the context during ACK; entries are left intact on pop
    always_ff @(posedge clk) begin
        if (state_q == ACK) begin
            stk_pc_q[push_idx]  <= pc_cur;
            stk_acc_q[push_idx] <= acc_cur;
            stk_flg_q[push_idx] <= flags_cur;
            stk_ie_q[push_idx]  <= ie_q;
        end
    end

endmodule

// File: doc/isr_dispatch.md
Name: isr_dispatch

Overview:
- CPU-side responder to the interrupt controller: accepts its pending flag and ISR vector at an instruction boundary.
- Saves the CPU context (PC, ACC, flags, interrupt-enable) on a small hardware stack and redirects the PC to the vector.
- Pulses the controller's pending-clear.
- On return-from-interrupt it pops the context and restores it.
- Sits between the interrupt controller and the accumulator CPU's fetch/PC logic.

Parameters:
- DEPTH, 2, context-stack entries (maximum nesting level).
- ADDR_W, 8, PC/vector width.
- DATA_W, 8, accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- i_pending  in  1  unmasked interrupt pending from the controller.
- vec_in  in  ADDR_W  ISR address from the controller.
- inst_done  in  1  CPU is at an instruction boundary this cycle.
- reti  in  1  the completing instruction is RETI (qualified by inst_done).
- ei  in  1  enable-interrupts instruction strobe.
- di  in  1  disable-interrupts instruction strobe.
- pc_cur  in  ADDR_W  address of the next instruction (return address).
- acc_cur  in  DATA_W  current accumulator.
- flags_cur  in  4  current ALU flags.
- itr_en  out  1  interrupt enable to the controller.
- itr_clr  out  1  one-cycle clear of the controller's pending register.
- cpu_stall  out  1  CPU must hold (no fetch/execute).
- pc_load  out  1  CPU loads pc_next this cycle.
- pc_next  out  ADDR_W  PC value to load.
- ctx_restore  out  1  CPU loads acc_rest/flags_rest this cycle.
- acc_rest  out  DATA_W  restored accumulator.
- flags_rest  out  4  restored flags.
- nest_depth  out  2  current stack occupancy, 0..DEPTH.
- reti_err  out  1  sticky: RETI executed at depth 0.

Behaviour:
- Reset (clr=1, asynchronous): state=RUN, ie_flag=0, depth=0, and every output 0, including itr_en, pc_next, acc_rest, flags_rest, nest_depth and reti_err. Reset mid-sequence aborts it with no partial push and no itr_clr.
- itr_en = ie_flag & (depth<DEPTH) & (state==RUN). It is combinational from registered state.
- ei/di: sampled only in RUN.
  - ei sets ie_flag; di clears it.
  - ei and di in the same cycle: di wins.
  - Both are ignored in ACK, JUMP and RESTORE.
- State machine:
  - RUN: cpu_stall=0.
    - On inst_done&reti: if depth>0, go to RESTORE; else set reti_err and stay in RUN.
    - Else on inst_done & i_pending & itr_en: go to ACK.
    - RETI has priority over a simultaneous pending interrupt; the pending interrupt is re-evaluated at the next boundary (tail-chain).
  - ACK (1 cycle): cpu_stall=1.
    - Latch vec_in into vec_q.
    - Push {pc_cur, acc_cur, flags_cur, ie_flag} at stack[depth], then depth+1.
    - ie_flag<=0.
    - Go to JUMP.
  - JUMP (1 cycle): cpu_stall=1, pc_load=1, pc_next=vec_q, itr_clr=1. Go to RUN.
  - RESTORE (1 cycle): cpu_stall=1, pc_load=1, ctx_restore=1.
    - pc_next/acc_rest/flags_rest come from stack[depth-1].
    - ie_flag<=saved ie bit; depth-1.
    - Go to RUN.
- Latency:
  - Boundary cycle N with a pending interrupt gives ACK at N+1 and pc_load/itr_clr at N+2.
  - RETI at boundary N gives pc_load/ctx_restore at N+1.
- Outputs pc_next/acc_rest/flags_rest hold their last driven value when pc_load=0.
- Stack full (depth==DEPTH): itr_en=0, so no entry occurs; the controller keeps the interrupt pending.
- i_pending deasserting between boundary and ACK is harmless; vec_in is latched in ACK regardless.
- Nesting occurs only if the ISR executes ei.
- Stack entries are not cleared on pop.

Test Plan:
- Entry:
  - Stimulus: ei, then i_pending=1, vec_in=0x96, pc_cur=0x12, acc_cur=0x5A, flags_cur=0x3, inst_done pulse.
  - Response: ACK next cycle; following cycle pc_load=1, pc_next=0x96, itr_clr=1; nest_depth=1, itr_en=0.
- Return:
  - Stimulus: from the entry state, inst_done+reti.
  - Response: next cycle pc_load=1, ctx_restore=1, pc_next=0x12, acc_rest=0x5A, flags_rest=0x3; nest_depth=0, itr_en=1.
- Nesting/full:
  - Stimulus: enter 0xC8, ei inside the ISR, enter 0xB4 (depth 2), ei, assert pending again.
  - Response: itr_en=0 and no third entry. Two RETIs return 0xB4-frame then 0xC8-frame PCs in LIFO order.
- Simultaneous: reti+i_pending at the same boundary at depth 1 -> RESTORE first, then the interrupt is taken at the next boundary.
- Error: reti with depth 0 -> reti_err=1 (sticky), no pc_load, state RUN.
- Reset: clr asserted during ACK -> all outputs 0 immediately, depth=0, no itr_clr pulse, itr_en=0 until ei.
